// File: rtl/delay_line_var_pkg.sv
// Shared definitions for the runtime-configurable FFT commutator delay line:
// sample-format defaults, lane access macro and depth helpers.
`ifndef FFT_SAMPLE_NB
`define FFT_SAMPLE_NB 32
`endif

// Lane k of a packed multi-lane bus of nb-bit samples.
`ifndef DLV_LANE
`define DLV_LANE(bus, k, nb) bus[(k)*(nb) +: (nb)]
`endif

package delay_line_var_pkg;

  localparam int NB_DEFAULT        = `FFT_SAMPLE_NB;
  localparam int NCH_DEFAULT       = 2;
  localparam int MAX_DEPTH_DEFAULT = 16;

  // Requested depth forced into 1..max_depth.
  function automatic int unsigned clamp_depth(input int unsigned req,
                                              input int unsigned max_depth);
    if (req == 0) return 1;
    if (req > max_depth) return max_depth;
    return req;
  endfunction

  // Address width for a ring of the given number of entries, at least 1 bit.
  function automatic int unsigned ring_addr_width(input int unsigned entries);
    if (entries <= 1) return 1;
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/delay_ring_ram.sv
// Simple dual-port storage for the delay line: one write port, one
// combinational read port, single clock. Write enable follows the line enable.
module delay_ring_ram #(
  parameter int W  = 65,
  parameter int N  = 15,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read returns the pre-write contents when raddr == waddr on a write edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_line_var.sv
// Enable-gated delay line of DEPTH (1..MAX_DEPTH) cycles for NCH lanes plus a
// valid flag; valid stays masked until the line is refilled after reset/cfg_load.
module delay_line_var
  import delay_line_var_pkg::*;
#(
  parameter  int NB        = NB_DEFAULT,
  parameter  int NCH       = NCH_DEFAULT,
  parameter  int MAX_DEPTH = MAX_DEPTH_DEFAULT,
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DW-1:0]     depth_cfg,
  input  logic              vld_in,
  input  logic [NCH*NB-1:0] data_in,
  output logic              vld_out,
  output logic [NCH*NB-1:0] data_out,
  output logic              fill_done
);

  localparam int DATA_W = NCH * NB;
  localparam int WORD_W = DATA_W + 1;
  localparam int RING_N = MAX_DEPTH - 1;
  localparam int AW     = ring_addr_width(RING_N);

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     wptr_next;
  logic [AW-1:0]     raddr;
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     depth_new;
  logic [DW-1:0]     fill_cnt;
  logic [DW-1:0]     cnt_inc;
  logic              filled_next;
  logic [31:0]       wp_ext;
  logic [31:0]       lag_ext;
  logic [WORD_W-1:0] in_word;
  logic [WORD_W-1:0] ring_rdata;
  logic [WORD_W-1:0] out_word;

  assign depth_new = DW'(clamp_depth(32'(depth_cfg), MAX_DEPTH));
  assign in_word   = {vld_in, data_in};

  // The ring holds the first D-1 stages; the output register is stage D.
  assign wptr_next = (wptr == AW'(RING_N - 1)) ? '0 : wptr + AW'(1);
  assign wp_ext    = 32'(wptr);
  assign lag_ext   = 32'(depth_q) - 32'd1;
  assign raddr     = AW'((wp_ext >= lag_ext) ? (wp_ext - lag_ext)
                                             : (wp_ext + 32'(RING_N) - lag_ext));

  delay_ring_ram #(
    .W  (WORD_W),
    .N  (RING_N),
    .AW (AW)
  ) u_ring (
    .clk   (clk),
    .we    (en),
    .waddr (wptr),
    .wdata (in_word),
    .raddr (raddr),
    .rdata (ring_rdata)
  );

  // D=1 has no ring stages: the output register samples the input directly.
  assign out_word = (depth_q == DW'(1)) ? in_word : ring_rdata;

  assign cnt_inc     = (fill_cnt >= depth_q) ? depth_q : fill_cnt + DW'(1);
  assign filled_next = (cnt_inc == depth_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      fill_cnt  <= '0;
      depth_q   <= DW'(MAX_DEPTH);
      data_out  <= '0;
      vld_out   <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      if (en) begin
        wptr     <= wptr_next;
        data_out <= out_word[DATA_W-1:0];
      end
      // A reconfigure restarts the fill so no old-config sample is flagged valid.
      if (cfg_load) begin
        depth_q   <= depth_new;
        fill_cnt  <= en ? DW'(1) : '0;
        vld_out   <= 1'b0;
        fill_done <= 1'b0;
      end else if (en) begin
        fill_cnt  <= cnt_inc;
        vld_out   <= out_word[WORD_W-1] & filled_next;
        fill_done <= filled_next;
      end
    end
  end

endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
- Runtime-configurable, enable-gated delay line for the FFT pipeline commutators. It replaces fixed-depth register-chain buffers.
- Delays NCH parallel lanes of NB-bit samples, plus a per-sample valid flag, by DEPTH enabled cycles. DEPTH is selectable at run time between 1 and MAX_DEPTH, so one instance serves every FFT size or stage setting.
- Supports pipeline stall via en, and a flush-on-reconfigure so stale samples are never flagged valid.

Parameters:
- NB, 32, sample width per lane (bits).
- NCH, 2, number of parallel lanes sharing one control path.
- MAX_DEPTH, 16, largest supported delay in enabled cycles; must be >= 2.
- DW, $clog2(MAX_DEPTH+1), width of the depth_cfg port (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; when 0 the whole block holds state.
- cfg_load  in  1  latch depth_cfg and restart filling.
- depth_cfg  in  DW  requested delay, sampled only when cfg_load=1.
- vld_in  in  1  input sample valid.
- data_in  in  NCH*NB  lane k at bits [k*NB +: NB].
- vld_out  out  1  delayed valid, masked until the line is filled.
- data_out  out  NCH*NB  delayed samples.
- fill_done  out  1  line holds DEPTH samples captured since the last reset or cfg_load.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=0, vld_out=0, fill_done=0.
  - Write pointer=0, fill counter=0, active depth=MAX_DEPTH.
  - Storage contents are not reset.
- Active depth D: depth_cfg clamped to 1..MAX_DEPTH (0 becomes 1, values > MAX_DEPTH become MAX_DEPTH). Latched on the rising edge where cfg_load=1, regardless of en.
- Timing equivalence: with D fixed, the block is cycle-equivalent to a chain of D registers all clock-enabled by en.
  - A sample accepted at enabled edge n appears on data_out/vld_out immediately after enabled edge n+D-1.
  - With D=1 it behaves as a single enabled register.
- en=0: no pointer, counter, output or storage change.
- Valid masking:
  - vld_out is the delayed vld_in AND'ed with the filled condition.
  - data_out is not masked; it carries whatever the line holds.
- Fill counter: saturates at D.
  - fill_done=1 once D enabled edges have occurred since reset or cfg_load.
  - The first valid output coincides with the edge on which fill_done rises.
- cfg_load edge:
  - New D is latched and fill counter restarts: set to 1 if en=1 on that edge, else 0.
  - If en=1, the sample on that edge is stored and counts as the first sample under the new D.
  - vld_out<=0 and fill_done<=0 on that edge. data_out updates normally if en=1.
  - cfg_load has priority over the fill logic.
- Storage:
  - Ring buffer of MAX_DEPTH-1 entries of NCH*NB+1 bits, plus the output register.
  - Read address = (wptr - (D-1)) mod (MAX_DEPTH-1). Read-before-write when the read and write addresses coincide (D=MAX_DEPTH).
  - Pointer wraps from MAX_DEPTH-2 to 0.
  - D=1 bypasses the ring: the output register takes the input directly.
- All lanes share pointer, counter and valid; there is no per-lane skew.

Decomposition:
- Shared package/header entries:
  - NB default, consistent with the existing FFT sample-format width macro.
  - Lane pack/unpack helper macro.
  - clamp_depth function.
- One natural sub-module: delay_ring_ram. It is a simple dual-port (1 write, 1 read, same clock) array with write enable tied to en. It is kept separate so it can later be mapped to block RAM.
- Control (pointer, fill counter, clamp, bypass mux) lives in the top module.

Test Plan:
- Reset mid-stream: assert rst_n=0 asynchronously between edges -> data_out=0, vld_out=0, fill_done=0 immediately; after release, first vld_out only after D fresh enabled edges.
- Fixed D=3, NCH=2, en=1, ramp lanes 0x10+n / 0x20+n -> output equals input 2 edges later. vld_out and fill_done rise on edge 3 after load.
- Stall: D=4, toggle en 1,0,0,1 pseudo-randomly -> output matches a 4-stage enabled-register reference model exactly; no change while en=0.
- Boundaries:
  - depth_cfg=0 -> behaves as D=1.
  - depth_cfg=16 -> D=16, wrap exercised over 40 samples, no corruption at pointer wrap.
  - depth_cfg=31 with MAX_DEPTH=16 -> clamped to D=16.
- Reconfigure on the fly: running D=8, cfg_load with depth_cfg=2 and en=1 on the same edge -> vld_out=0 on that edge. The sample on that edge is output with vld_out=1 one edge later (2nd enabled edge after load); no old-config sample is ever flagged valid.
- Valid gaps: D=5, vld_in pattern 1,0,1,1,0 -> vld_out reproduces the pattern 4 edges later once filled.
